// File: rtl/rlight_sched.sv
// rlight_sched: register-programmed LED step sequencer driving a shift datapath.
// Define RLIGHT_SCHED_IRQ_EN to enable the completion interrupt pulse on irq_o.
module rlight_sched #(
  parameter int NUM_STEPS = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        we_i,
  input  logic        re_i,
  input  logic [5:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic [1:0]  mode_o,
  output logic [7:0]  pattern_o,
  output logic        load_o,
  output logic        tick_o,
  output logic        busy_o,
  output logic        irq_o
);
  localparam logic [4:0] NS = 5'(NUM_STEPS);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, NEXT} state_t;
  state_t st, nxt;
  logic [31:0] prog [16];
  logic [31:0] cur;
  logic [3:0] idx, last, eidx;
  logic [7:0] d, c, dl;
  logic loop, done, ctrl_wr, start, stop, ent_ok, fin, wrap;
  assign ctrl_wr = we_i && addr_i == 6'h00;
  assign stop = ctrl_wr && wdata_i[1];
  assign start = ctrl_wr && wdata_i[0] && !wdata_i[1];
  assign eidx = {1'b0, addr_i[4:2]};
  assign ent_ok = addr_i[5] && addr_i[1:0] == 2'b00 && {1'b0, eidx} < NS;
  assign cur = prog[idx];
  assign wrap = idx == last;
  always_comb begin
    load_o = st == LOAD;
    pattern_o = load_o ? cur[7:0] : 8'h00;
    tick_o = st == RUN && c != 8'd0 && d == 8'd0 && mode_o != 2'd3 && !stop;
    busy_o = st != IDLE;
    fin = st == NEXT && wrap && !loop && !stop;
    nxt = stop ? IDLE :
          st == IDLE ? (start ? LOAD : IDLE) :
          st == LOAD ? RUN :
          st == RUN  ? (c == 8'd0 ? NEXT : RUN) :
          (wrap && !loop ? IDLE : LOAD);
  end
  always_comb begin
    rdata_o = !re_i ? 32'h0 :
              addr_i == 6'h00 ? {29'h0, loop, 2'b00} :
              addr_i == 6'h04 ? {20'h0, idx, 6'h0, done, busy_o} :
              addr_i == 6'h08 ? {28'h0, last} :
              ent_ok ? prog[eidx] : 32'h0;
  end
`ifdef RLIGHT_SCHED_IRQ_EN
  assign irq_o = fin;
`else
  assign irq_o = 1'b0;
`endif
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) st <= IDLE;
    else st <= nxt;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx <= 4'd0;
      last <= 4'(NUM_STEPS - 1);
      loop <= 1'b0;
      done <= 1'b0;
      mode_o <= 2'd3;
      d <= 8'd0;
      c <= 8'd0;
      dl <= 8'd0;
      for (int i = 0; i < 16; i++) prog[i] <= 32'h0;
    end else begin
      if (ctrl_wr) loop <= wdata_i[2];
      if (we_i && addr_i == 6'h08 && {1'b0, wdata_i[3:0]} < NS) last <= wdata_i[3:0];
      if (we_i && ent_ok) prog[eidx] <= wdata_i & 32'hFFFF_03FF;
      if (fin) done <= 1'b1;
      else if (st == IDLE && start) done <= 1'b0;
      else if (we_i && addr_i == 6'h04 && wdata_i[1]) done <= 1'b0;
      if (!stop) begin
        if (st == IDLE && start) idx <= 4'd0;
        if (st == LOAD) begin
          mode_o <= cur[9:8];
          d <= cur[23:16];
          dl <= cur[23:16];
          c <= cur[31:24];
        end
        // reload from the latched delay so mid-step entry rewrites cannot disturb it
        if (st == RUN && c != 8'd0) begin
          if (d != 8'd0) d <= d - 8'd1;
          else begin
            c <= c - 8'd1;
            d <= dl;
          end
        end
        if (st == NEXT && !(wrap && !loop)) idx <= wrap ? 4'd0 : idx + 4'd1;
      end
    end
  end
endmodule
